fix_tx_buffer: RTL and testbench

- Store-and-forward byte FIFO directly downstream of fix_engine.
- Absorbs the engine's outbound stream (fifo_write_o / message_o) and drives the engine's fifo_full_i back-pressure.
- Detects the FIX checksum trailer ("<SOH>10=ddd<SOH>") to find message boundaries.
- Releases only complete messages to the TOE transmit side over a valid/ready handshake, with a last-byte marker.

---
 rtl/fix_pkg.sv | 21 ++
 rtl/fix_tx_buffer_if.sv | 15 +
 rtl/fix_trailer_det.sv | 42 ++++
 rtl/fix_tx_buffer.sv | 84 ++++++++
 tb/tb_fix_tx_buffer.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/fix_pkg.sv
// Shared constants and types for the FIX transmit buffer: trailer-match states and FIFO entry layout.
package fix_pkg;
    localparam logic [7:0] SOH_DEF = 8'h01;
    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_1    = 8'h31;
    localparam logic [7:0] CH_9    = 8'h39;
    localparam logic [7:0] CH_EQ   = 8'h3d;

    typedef enum logic [2:0] {
        S_NONE, S_SOH, S_1, S_10, S_EQ, S_D1, S_D2, S_D3
    } trl_state_e;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } entry_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= CH_0) && (b <= CH_9);
    endfunction
endpackage

// File: rtl/fix_tx_buffer_if.sv
// Byte-stream bus around the transmit buffer: engine write side plus TOE valid/ready read side.
interface fix_tx_buffer_if;
    logic       wr_en_i;
    logic [7:0] wr_data_i;
    logic       full_o;
    logic       tx_valid_o;
    logic [7:0] tx_data_o;
    logic       tx_last_o;
    logic       tx_ready_i;

    modport master (output wr_en_i, wr_data_i, tx_ready_i,
                    input  full_o, tx_valid_o, tx_data_o, tx_last_o);
    modport slave  (input  wr_en_i, wr_data_i, tx_ready_i,
                    output full_o, tx_valid_o, tx_data_o, tx_last_o);
endinterface

// File: rtl/fix_trailer_det.sv
// Watches accepted bytes for the "<SOH>10=ddd<SOH>" checksum trailer; pulses commit_o with the closing SOH.
module fix_trailer_det import fix_pkg::*; #(
    parameter logic [7:0] SOH_CHAR = SOH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_vld_i,
    input  logic [7:0] byte_i,
    output logic       commit_o
);
    trl_state_e state_q, state_d, miss;
    logic       is_soh;

    assign is_soh = (byte_i == SOH_CHAR);
    // A stray SOH may itself be the start of a new trailer.
    assign miss   = is_soh ? S_SOH : S_NONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_NONE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (byte_vld_i) begin
            case (state_q)
                S_NONE:  state_d = miss;
                S_SOH:   state_d = (byte_i == CH_1)  ? S_1  : miss;
                S_1:     state_d = (byte_i == CH_0)  ? S_10 : miss;
                S_10:    state_d = (byte_i == CH_EQ) ? S_EQ : miss;
                S_EQ:    state_d = is_digit(byte_i)  ? S_D1 : miss;
                S_D1:    state_d = is_digit(byte_i)  ? S_D2 : miss;
                S_D2:    state_d = is_digit(byte_i)  ? S_D3 : miss;
                default: state_d = S_NONE;
            endcase
        end
    end

    always_comb begin
        commit_o = byte_vld_i && (state_q == S_D3) && is_soh;
    end
endmodule

// File: rtl/fix_tx_buffer.sv
// Store-and-forward byte FIFO: releases only complete FIX messages, with cut-through when a message outgrows the buffer.
module fix_tx_buffer import fix_pkg::*; #(
    parameter int         DEPTH    = 256,
    parameter int         ADDR_W   = $clog2(DEPTH),
    parameter logic [7:0] SOH_CHAR = SOH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    fix_tx_buffer_if.slave    bus,
    output logic [ADDR_W:0]   msg_count_o,
    output logic              overflow_o,
    output logic              oversize_o
);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    entry_t            mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d, msg_cnt_q, msg_cnt_d;
    logic              cut_q, cut_d, ovf_q, ovf_d, ovs_q, ovs_d;
    logic              full, empty, stuck, wr_acc, rd_acc, rd_last, commit, tx_valid;
    entry_t            head;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    // Buffer full with no complete message inside can never drain on its own.
    assign stuck    = full && (msg_cnt_q == '0);
    assign wr_acc   = bus.wr_en_i && !full;
    assign head     = mem_q[rd_ptr_q];
    assign tx_valid = !empty && ((msg_cnt_q != '0) || cut_q);
    assign rd_acc   = tx_valid && bus.tx_ready_i;
    assign rd_last  = rd_acc && head.last;

    fix_trailer_det #(.SOH_CHAR(SOH_CHAR)) u_det (
        .clk        (clk),
        .rst        (rst),
        .byte_vld_i (wr_acc),
        .byte_i     (bus.wr_data_i),
        .commit_o   (commit)
    );

    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= entry_t'{last: commit, data: bus.wr_data_i};
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q + ADDR_W'(wr_acc);
        rd_ptr_d  = rd_ptr_q + ADDR_W'(rd_acc);
        count_d   = count_q + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_acc);
        msg_cnt_d = msg_cnt_q + (ADDR_W+1)'(commit) - (ADDR_W+1)'(rd_last);
        cut_d     = cut_q;
        if (stuck)        cut_d = 1'b1;
        else if (rd_last) cut_d = 1'b0;
        ovf_d     = ovf_q | (bus.wr_en_i & full);
        ovs_d     = ovs_q | stuck;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            msg_cnt_q <= '0;
            cut_q     <= 1'b0;
            ovf_q     <= 1'b0;
            ovs_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            msg_cnt_q <= msg_cnt_d;
            cut_q     <= cut_d;
            ovf_q     <= ovf_d;
            ovs_q     <= ovs_d;
        end
    end

    assign bus.full_o     = full;
    assign bus.tx_valid_o = tx_valid;
    assign bus.tx_data_o  = tx_valid ? head.data : 8'h00;
    assign bus.tx_last_o  = tx_valid && head.last;
    assign msg_count_o    = msg_cnt_q;
    assign overflow_o     = ovf_q;
    assign oversize_o     = ovs_q;
endmodule

// File: tb/tb_fix_tx_buffer.sv
// Scoreboard bench: a 256-deep buffer for message framing tests and a 16-deep one for cut-through/overflow.
module tb_fix_tx_buffer;
    import fix_pkg::*;

    localparam logic [7:0] SOH = 8'h3b;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fix_tx_buffer_if bif();
    fix_tx_buffer_if sif();
    logic [8:0] b_msg;
    logic [4:0] s_msg;
    logic       b_ovf, b_ovs, s_ovf, s_ovs;

    fix_tx_buffer #(.DEPTH(256), .SOH_CHAR(SOH)) u_big (
        .clk(clk), .rst(rst), .bus(bif),
        .msg_count_o(b_msg), .overflow_o(b_ovf), .oversize_o(b_ovs));

    fix_tx_buffer #(.DEPTH(16), .SOH_CHAR(SOH)) u_small (
        .clk(clk), .rst(rst), .bus(sif),
        .msg_count_o(s_msg), .overflow_o(s_ovf), .oversize_o(s_ovs));

    int     checks = 0;
    int     errors = 0;
    entry_t bq[$];
    entry_t sq[$];
    entry_t be, se;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: pop the expected byte whenever a transfer is about to happen.
    always @(negedge clk) begin
        if (!rst && bif.tx_valid_o && bif.tx_ready_i) begin
            checks++;
            if (bq.size() == 0) begin
                errors++;
                $display("FAIL big_out: got %h last %b expected no byte", bif.tx_data_o, bif.tx_last_o);
            end else begin
                be = bq.pop_front();
                if (bif.tx_data_o !== be.data || bif.tx_last_o !== be.last) begin
                    errors++;
                    $display("FAIL big_out: got %h last %b expected %h last %b",
                             bif.tx_data_o, bif.tx_last_o, be.data, be.last);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && sif.tx_valid_o && sif.tx_ready_i) begin
            checks++;
            if (sq.size() == 0) begin
                errors++;
                $display("FAIL small_out: got %h last %b expected no byte", sif.tx_data_o, sif.tx_last_o);
            end else begin
                se = sq.pop_front();
                if (sif.tx_data_o !== se.data || sif.tx_last_o !== se.last) begin
                    errors++;
                    $display("FAIL small_out: got %h last %b expected %h last %b",
                             sif.tx_data_o, sif.tx_last_o, se.data, se.last);
                end
            end
        end
    end

    // One byte per cycle; drop=1 means the byte must be refused, so nothing is expected.
    task automatic wr(input bit d, input logic [7:0] c, input bit last, input bit drop);
        if (d == 1'b0) begin
            bif.wr_en_i = 1'b1; bif.wr_data_i = c;
            if (!drop) bq.push_back(entry_t'{last: last, data: c});
        end else begin
            sif.wr_en_i = 1'b1; sif.wr_data_i = c;
            if (!drop) sq.push_back(entry_t'{last: last, data: c});
        end
        @(posedge clk); #1;
    endtask

    task automatic send(input bit d, input string s, input bit commit);
        for (int i = 0; i < s.len(); i++) wr(d, s[i], commit && (i == s.len() - 1), 1'b0);
        if (d == 1'b0) bif.wr_en_i = 1'b0; else sif.wr_en_i = 1'b0;
    endtask

    task automatic drain(input bit d, input string name);
        int n;
        n = 0;
        if (d == 1'b0) bif.tx_ready_i = 1'b1; else sif.tx_ready_i = 1'b1;
        while (n < 400) begin
            @(posedge clk); #1;
            n++;
            if (d == 1'b0 && bq.size() == 0 && !bif.tx_valid_o) break;
            if (d == 1'b1 && sq.size() == 0 && !sif.tx_valid_o) break;
        end
        chk({name, "_drain_in_time"}, 32'(n < 400), 32'd1);
        if (d == 1'b0) bif.tx_ready_i = 1'b0; else sif.tx_ready_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bif.wr_en_i = 1'b0; bif.wr_data_i = 8'h00; bif.tx_ready_i = 1'b0;
        sif.wr_en_i = 1'b0; sif.wr_data_i = 8'h00; sif.tx_ready_i = 1'b0;
        #12;
        chk("rst_valid", bif.tx_valid_o, 0);
        chk("rst_full",  bif.full_o, 0);
        chk("rst_data",  bif.tx_data_o, 0);
        chk("rst_last",  bif.tx_last_o, 0);
        chk("rst_msg",   b_msg, 0);
        chk("rst_flags", {b_ovf, b_ovs, s_ovf, s_ovs, sif.tx_valid_o}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single message held until its closing SOH, then drained.
        send(0, "8=FIX.4.2;9=5;10=123", 0);
        chk("t1_pre_valid", bif.tx_valid_o, 0);
        chk("t1_pre_msg", b_msg, 0);
        send(0, ";", 1);
        chk("t1_msg", b_msg, 1);
        chk("t1_valid", bif.tx_valid_o, 1);
        chk("t1_head", bif.tx_data_o, 32'h38);
        drain(0, "t1");
        chk("t1_msg_end", b_msg, 0);

        // Partial message stalls until the trailer completes.
        send(0, "8=FIX;10=12", 0);
        repeat (5) @(posedge clk);
        #1;
        chk("t2_stall_valid", bif.tx_valid_o, 0);
        chk("t2_stall_msg", b_msg, 0);
        send(0, "3;", 1);
        chk("t2_msg", b_msg, 1);
        drain(0, "t2");

        // Near-miss trailers do not commit; the final SOH leaves a valid trailer start.
        send(0, ";10=1a3;", 0);
        chk("t3_miss1_msg", b_msg, 0);
        send(0, ";110=123;", 0);
        chk("t3_miss2_msg", b_msg, 0);
        chk("t3_miss2_valid", bif.tx_valid_o, 0);
        send(0, "10=123;", 1);
        chk("t3_msg", b_msg, 1);
        drain(0, "t3");

        // Back-to-back: second commit lands on the same edge as the first message's last read.
        bif.tx_ready_i = 1'b1;
        send(0, "A;10=000;", 1);
        chk("t4_first_msg", b_msg, 1);
        send(0, "B;10=999;", 1);
        chk("t4_overlap_msg", b_msg, 1);
        chk("t4_overlap_valid", bif.tx_valid_o, 1);
        drain(0, "t4");
        chk("t4_msg_end", b_msg, 0);

        // 16-deep buffer, 20-byte message: fills, forces cut-through, drops writes while full.
        send(1, "8=FIX;9=XXXX;10=", 0);
        chk("t5_full", sif.full_o, 1);
        chk("t5_full_valid", sif.tx_valid_o, 0);
        chk("t5_full_ovs", s_ovs, 0);
        wr(1, "Z", 0, 1);
        sif.wr_en_i = 1'b0;
        chk("t5_ovf", s_ovf, 1);
        chk("t5_ovs", s_ovs, 1);
        chk("t5_cut_valid", sif.tx_valid_o, 1);
        chk("t5_cut_head", sif.tx_data_o, 32'h38);
        chk("t5_cut_last", sif.tx_last_o, 0);
        sif.tx_ready_i = 1'b1;
        wr(1, "Y", 0, 1);
        sif.wr_en_i = 1'b0;
        chk("t5_after_rd_full", sif.full_o, 0);
        send(1, "123;", 1);
        drain(1, "t5");
        chk("t5_msg_end", s_msg, 0);
        chk("t5_ovs_sticky", s_ovs, 1);
        sif.tx_ready_i = 1'b1;
        send(1, "abc", 0);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_cut_cleared", sif.tx_valid_o, 0);
        sif.tx_ready_i = 1'b0;

        // Reset in the middle of a drain clears everything asynchronously.
        send(0, "8=FIX;10=456;", 1);
        bif.tx_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        bq.delete();
        sq.delete();
        #1;
        chk("t6_valid", bif.tx_valid_o, 0);
        chk("t6_data", bif.tx_data_o, 0);
        chk("t6_last", bif.tx_last_o, 0);
        chk("t6_msg", b_msg, 0);
        chk("t6_small", {s_ovf, s_ovs, sif.full_o, sif.tx_valid_o}, 0);
        bif.tx_ready_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        send(0, "X;10=789;", 1);
        chk("t6_new_msg", b_msg, 1);
        drain(0, "t6");
        chk("t6_msg_end", b_msg, 0);

        chk("end_big_queue", bq.size(), 0);
        chk("end_small_queue", sq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
